ro_measure_sequencer: RTL and testbench

// - Sequences a sweep of ring-oscillator frequency measurements for the RO PUF.
//   Per oscillator: select, enable, clear the shared edge counter, time a counting window, capture the count.
// - After the last oscillator, compares adjacent counts to form the response word.
// - Sits between the challenge/response host interface and the RO bank + shared counter datapath.

---
 rtl/ro_puf_pkg.sv | 18 +
 rtl/ro_measure_sequencer_timer.sv | 35 +++
 rtl/ro_measure_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_ro_measure_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_puf_pkg.sv
// Shared definitions for the RO PUF measurement sequencer.
// Contents: default geometry constants and the sequencer state encoding.
package ro_puf_pkg;

  localparam int unsigned DEF_NUM_RO = 9;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_COUNT,
    ST_CAPTURE,
    ST_COMPARE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ro_measure_sequencer_timer.sv
// ro_window_timer: loadable down-counter with a zero flag.
// One instance times both the settle interval and the counting window.
// Ports:
//   count_clk  clock
//   reset      asynchronous, active-high
//   load       load load_val (has priority over dec)
//   dec        decrement by one, saturating at zero
//   load_val   value loaded on load
//   zero       high while the count is zero
module ro_window_timer #(
  parameter int unsigned W = 16
) (
  input  logic         count_clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge count_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ro_measure_sequencer.sv
// ro_measure_sequencer: sweeps the RO bank, capturing one shared-counter
// window per oscillator, then forms the response from adjacent-count
// comparisons.
// Ports:
//   count_clk, reset (async, active-high)
//   start, challenge      host request; challenge latched when start accepted
//   ro_cfg, ro_sel, ro_en RO bank control
//   cnt_clr, cnt_en       shared counter control; cnt_value its output
//   busy, done            sweep status
//   response, sat_err     result, valid while done
// Build option: RO_PUF_MAJORITY_EN runs three sweeps and majority-votes
// the per-pass comparison bits; sat_err is the OR over all passes.
module ro_measure_sequencer
  import ro_puf_pkg::*;
#(
  parameter int unsigned NUM_RO = DEF_NUM_RO,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned WINDOW = 16'hFFFF,
  parameter int unsigned SETTLE = 4
) (
  input  logic                      count_clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [7:0]                challenge,
  output logic [5:0]                ro_cfg,
  output logic [$clog2(NUM_RO)-1:0] ro_sel,
  output logic                      ro_en,
  output logic                      cnt_clr,
  output logic                      cnt_en,
  input  logic [CNT_W-1:0]          cnt_value,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_RO-2:0]         response,
  output logic                      sat_err
);

  localparam int unsigned SEL_W       = $clog2(NUM_RO);
  localparam int unsigned SPAN        = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int unsigned TMR_W       = $clog2(SPAN + 1);
  localparam int unsigned SETTLE_LOAD = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_RO - 1);

  state_t             state, state_next;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]   tmr_load_val;
  logic [CNT_W-1:0]   cnt_q [NUM_RO];
  logic [NUM_RO-2:0]  cmp_bits;
  logic               sat_any;
  logic               last_pass;
  logic               unused_chal_hi;

  assign unused_chal_hi = ^challenge[7:6];

`ifdef RO_PUF_MAJORITY_EN
  logic [1:0]        pass_q;
  logic [NUM_RO-2:0] vote_a, vote_b;
  logic              sat_acc;
  assign last_pass = (pass_q == 2'd2);
`else
  assign last_pass = 1'b1;
`endif

  ro_window_timer #(.W(TMR_W)) u_timer (
    .count_clk (count_clk),
    .reset     (reset),
    .load      (tmr_load),
    .dec       (tmr_dec),
    .load_val  (tmr_load_val),
    .zero      (tmr_zero)
  );

  always_ff @(posedge count_clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // The timer is loaded with N-1 on entry so a phase lasts exactly N cycles.
  always_comb begin
    state_next   = state;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    tmr_load_val = TMR_W'(WINDOW - 1);
    case (state)
      ST_IDLE:    if (start) state_next = ST_CLEAR;
      ST_CLEAR: begin
        tmr_load = 1'b1;
        if (SETTLE > 0) begin
          tmr_load_val = TMR_W'(SETTLE_LOAD);
          state_next   = ST_SETTLE;
        end else begin
          state_next   = ST_COUNT;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          tmr_load   = 1'b1;
          state_next = ST_COUNT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_COUNT: begin
        if (tmr_zero) state_next = ST_CAPTURE;
        else          tmr_dec    = 1'b1;
      end
      ST_CAPTURE: state_next = (ro_sel == LAST_SEL) ? ST_COMPARE : ST_CLEAR;
      ST_COMPARE: state_next = last_pass ? ST_DONE : ST_CLEAR;
      ST_DONE:    if (!start) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // busy hands over to done without a gap (done is one cycle behind DONE).
  always_comb begin
    ro_en   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    busy    = (state != ST_IDLE) && !done;
    case (state)
      ST_CLEAR:   begin ro_en = 1'b1; cnt_clr = 1'b1; end
      ST_SETTLE:  ro_en = 1'b1;
      ST_COUNT:   begin ro_en = 1'b1; cnt_en = 1'b1; end
      ST_CAPTURE: ro_en = 1'b1;
      default:    ;
    endcase
  end

  always_comb begin
    cmp_bits = '0;
    sat_any  = 1'b0;
    for (int unsigned i = 0; i < NUM_RO - 1; i++) begin
      cmp_bits[i] = (cnt_q[i+1] > cnt_q[i]);
    end
    for (int unsigned i = 0; i < NUM_RO; i++) begin
      sat_any = sat_any | (cnt_q[i] == '1);
    end
  end

  always_ff @(posedge count_clk or posedge reset) begin
    if (reset) begin
      ro_cfg   <= '0;
      ro_sel   <= '0;
      done     <= 1'b0;
      response <= '0;
      sat_err  <= 1'b0;
      for (int unsigned i = 0; i < NUM_RO; i++) cnt_q[i] <= '0;
`ifdef RO_PUF_MAJORITY_EN
      pass_q  <= '0;
      vote_a  <= '0;
      vote_b  <= '0;
      sat_acc <= 1'b0;
`endif
    end else begin
      done <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            ro_cfg <= challenge[5:0];
            ro_sel <= '0;
`ifdef RO_PUF_MAJORITY_EN
            pass_q <= '0;
`endif
          end
        end
        ST_CAPTURE: begin
          cnt_q[ro_sel] <= cnt_value;
          if (ro_sel != LAST_SEL) ro_sel <= ro_sel + 1'b1;
        end
        ST_COMPARE: begin
`ifdef RO_PUF_MAJORITY_EN
          case (pass_q)
            2'd0: begin
              vote_a  <= cmp_bits;
              sat_acc <= sat_any;
              pass_q  <= 2'd1;
              ro_sel  <= '0;
            end
            2'd1: begin
              vote_b  <= cmp_bits;
              sat_acc <= sat_acc | sat_any;
              pass_q  <= 2'd2;
              ro_sel  <= '0;
            end
            default: begin
              response <= (vote_a & vote_b) | (vote_a & cmp_bits) | (vote_b & cmp_bits);
              sat_err  <= sat_acc | sat_any;
              pass_q   <= '0;
            end
          endcase
`else
          response <= cmp_bits;
          sat_err  <= sat_any;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_measure_sequencer.sv
module tb_ro_measure_sequencer;

  localparam int unsigned NUM_RO = 9;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WINDOW = 16;
  localparam int unsigned SETTLE = 2;
`ifdef RO_PUF_MAJORITY_EN
  localparam int unsigned PASSES = 3;
`else
  localparam int unsigned PASSES = 1;
`endif
  localparam int unsigned LAT = PASSES * NUM_RO * (WINDOW + SETTLE + 2) + PASSES + 1;

  logic             count_clk = 1'b0;
  logic             reset;
  logic             start;
  logic [7:0]       challenge;
  logic [5:0]       ro_cfg;
  logic [3:0]       ro_sel;
  logic             ro_en, cnt_clr, cnt_en;
  logic [CNT_W-1:0] cnt_value;
  logic             busy, done;
  logic [7:0]       response;
  logic             sat_err;

  ro_measure_sequencer #(
    .NUM_RO (NUM_RO),
    .CNT_W  (CNT_W),
    .WINDOW (WINDOW),
    .SETTLE (SETTLE)
  ) dut (
    .count_clk (count_clk),
    .reset     (reset),
    .start     (start),
    .challenge (challenge),
    .ro_cfg    (ro_cfg),
    .ro_sel    (ro_sel),
    .ro_en     (ro_en),
    .cnt_clr   (cnt_clr),
    .cnt_en    (cnt_en),
    .cnt_value (cnt_value),
    .busy      (busy),
    .done      (done),
    .response  (response),
    .sat_err   (sat_err)
  );

  always #5 count_clk = ~count_clk;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int unsigned cyc       = 0;

  initial forever begin
    @(posedge count_clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Shared counter model: counts enabled cycles; a full window returns the
  // target frequency count for the oscillator currently selected.
  logic [CNT_W-1:0] tgt [PASSES][NUM_RO];
  int unsigned      en_cycles;
  int               pass_num;
  int unsigned      pidx;

  always @(posedge count_clk or posedge reset) begin
    if (reset)        en_cycles <= 0;
    else if (cnt_clr) en_cycles <= 0;
    else if (cnt_en)  en_cycles <= en_cycles + 1;
  end

  always @(posedge count_clk or posedge reset) begin
    if (reset || !busy)                 pass_num <= -1;
    else if (cnt_clr && ro_sel == 4'd0) pass_num <= pass_num + 1;
  end

  assign pidx = (pass_num <= 0) ? 0 :
                (pass_num >= int'(PASSES)) ? PASSES - 1 : int'(pass_num);
  assign cnt_value = (en_cycles == WINDOW) ? tgt[pidx][ro_sel] : CNT_W'(en_cycles);

  task automatic set_lin(input int base, input int step);
    for (int p = 0; p < int'(PASSES); p++)
      for (int i = 0; i < int'(NUM_RO); i++)
        tgt[p][i] = CNT_W'(base + step * i);
  endtask

  // Scoreboard
  typedef struct {
    logic [7:0]  resp;
    logic        sat;
    int unsigned accept;
  } exp_t;
  exp_t sb[$];

  initial begin : done_mon
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge count_clk);
      if (reset) begin
        done_prev = 1'b0;
      end else begin
        if (done && !done_prev) begin
          if (sb.size() == 0) begin
            check("unexpected_done", done, 1'b0);
          end else begin
            e = sb.pop_front();
            check("response", response, e.resp);
            check("sat_err", sat_err, e.sat);
            check("latency", cyc - e.accept, LAT);
          end
        end
        done_prev = done;
      end
    end
  end

  // Per-phase monitor: ro_sel order, settle length, window length.
  initial begin : phase_mon
    int          phase;
    int unsigned exp_sel, settle_n, en_n;
    phase = 0; exp_sel = 0; settle_n = 0; en_n = 0;
    forever begin
      @(negedge count_clk);
      if (reset || !busy) begin
        phase = 0; exp_sel = 0;
      end else if (cnt_clr) begin
        check("clr_sel", ro_sel, exp_sel);
        check("clr_ro_en", ro_en, 1'b1);
        phase = 1; settle_n = 0; en_n = 0;
      end else if (cnt_en) begin
        if (phase == 1) begin
          check("settle_len", settle_n, SETTLE);
          check("count_ro_en", ro_en, 1'b1);
          phase = 2;
        end
        en_n++;
      end else if (ro_en) begin
        if (phase == 1) begin
          settle_n++;
        end else if (phase == 2) begin
          check("window_len", en_n, WINDOW);
          check("capture_sel", ro_sel, exp_sel);
          exp_sel = (exp_sel + 1) % NUM_RO;
          phase = 0;
        end
      end
    end
  end

  task automatic start_sweep(input logic [7:0] chal, input bit expect_done,
                             input logic [7:0] er, input logic es);
    exp_t e;
    @(negedge count_clk);
    start = 1'b1;
    challenge = chal;
    if (expect_done) begin
      e.resp = er; e.sat = es; e.accept = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag);
    int unsigned n;
    n = 0;
    while (!done && n < LAT + 50) begin
      @(negedge count_clk);
      n++;
    end
    if (!done) begin
      check({tag, "_timeout"}, done, 1'b1);
      sb.delete();
    end
  endtask

  task automatic release_start;
    @(negedge count_clk);
    start = 1'b0;
    repeat (2) @(negedge count_clk);
  endtask

  initial begin : stim
    bit any_act;
    exp_t e;
    reset = 1'b1; start = 1'b0; challenge = 8'h00;
    set_lin(10, 10);
    repeat (3) @(negedge count_clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ro_en", ro_en, 1'b0);
    check("rst_cnt_en", cnt_en, 1'b0);
    check("rst_cnt_clr", cnt_clr, 1'b0);
    check("rst_response", response, 8'h00);
    check("rst_ro_cfg", ro_cfg, 6'h00);
    reset = 1'b0;
    repeat (2) @(negedge count_clk);

    // Ascending counts, challenge changed mid-sweep, start held after done.
    start_sweep(8'hA5, 1'b1, 8'hFF, 1'b0);
    repeat (30) @(negedge count_clk);
    challenge = 8'h5A;
    repeat (10) @(negedge count_clk);
    check("cfg_hold", ro_cfg, 6'h25);
    check("busy_mid", busy, 1'b1);
    wait_done("asc");
    any_act = 1'b0;
    repeat (40) begin
      @(negedge count_clk);
      if (ro_en || busy || !done) any_act = 1'b1;
    end
    check("no_retrigger", any_act, 1'b0);
    release_start();
    check("done_clear", done, 1'b0);
    check("resp_held_idle", response, 8'hFF);
    check("cfg_after", ro_cfg, 6'h25);

    // Equal counts compare as 0.
    set_lin(50, 0);
    start_sweep(8'h3C, 1'b1, 8'h00, 1'b0);
    wait_done("equal");
    release_start();

    // Descending counts.
    set_lin(100, -10);
    start_sweep(8'h11, 1'b1, 8'h00, 1'b0);
    wait_done("desc");
    release_start();

    // Saturated count in position 4.
    for (int p = 0; p < int'(PASSES); p++) tgt[p][4] = 16'hFFFF;
    start_sweep(8'h22, 1'b1, 8'h08, 1'b1);
    wait_done("sat");
    release_start();

    // Reset mid-sweep then full restart.
    set_lin(10, 10);
    start_sweep(8'h0F, 1'b0, 8'h00, 1'b0);
    repeat (70) @(negedge count_clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_ro_en", ro_en, 1'b0);
    check("abort_cnt_en", cnt_en, 1'b0);
    check("abort_response", response, 8'h00);
    check("abort_sat", sat_err, 1'b0);
    check("abort_ro_sel", ro_sel, 4'd0);
    check("abort_ro_cfg", ro_cfg, 6'h00);
    @(negedge count_clk);
    reset = 1'b0;
    e.resp = 8'hFF; e.sat = 1'b0; e.accept = cyc + 1;
    sb.push_back(e);
    wait_done("restart");
    release_start();

`ifdef RO_PUF_MAJORITY_EN
    // Pass 2 inverted; majority follows passes 1 and 3.
    set_lin(10, 10);
    for (int i = 0; i < int'(NUM_RO); i++) tgt[1][i] = CNT_W'(100 - 10 * i);
    start_sweep(8'h07, 1'b1, 8'hFF, 1'b0);
    wait_done("majority");
    release_start();
`endif

    repeat (3) @(negedge count_clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
